// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: valid/ready handshake with one skid entry, flush,
// load-data extraction and a forwarding port toward EX.
module mem_wb_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_mem_to_reg,
  input  logic                  in_reg_write,
  input  logic [2:0]            in_funct3,
  input  logic [XLEN-1:0]       in_mem_addr,
  input  logic [XLEN-1:0]       in_read_data,
  input  logic [REG_ADDR_W-1:0] in_rd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_reg_write,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_wb_data,
  output logic                  out_load_err,
  output logic                  fwd_en,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data
);

  localparam int OFF_W   = (XLEN == 64) ? 3 : 2;
  localparam bit IS_RV32 = (XLEN == 32);

  typedef struct packed {
    logic                  reg_write;
    logic                  load_err;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       wb_data;
  } wb_entry_t;

  // Builds a complete write-back entry; a bad load zeroes the data and kills the write.
  function automatic wb_entry_t build_entry(
    input logic                  mem_to_reg,
    input logic                  reg_write,
    input logic [2:0]            funct3,
    input logic [XLEN-1:0]       addr,
    input logic [XLEN-1:0]       rdata,
    input logic [REG_ADDR_W-1:0] rd
  );
    wb_entry_t   entry;
    logic [2:0]  off;
    logic [31:0] lane;
    logic [XLEN-1:0] value;
    logic        bad;
    off   = 3'(addr[OFF_W-1:0]);
    lane  = 32'(rdata >> {off, 3'b000});
    value = '0;
    bad   = 1'b0;
    if (mem_to_reg) begin
      case (funct3)
        3'b000: value = XLEN'($signed(lane[7:0]));
        3'b100: value = XLEN'(lane[7:0]);
        3'b001: begin
          bad   = off[0];
          value = XLEN'($signed(lane[15:0]));
        end
        3'b101: begin
          bad   = off[0];
          value = XLEN'(lane[15:0]);
        end
        3'b010: begin
          bad   = (off[1:0] != 2'b00);
          value = XLEN'($signed(lane[31:0]));
        end
        3'b110: begin
          bad   = IS_RV32 || (off[1:0] != 2'b00);
          value = XLEN'(lane[31:0]);
        end
        3'b011: begin
          bad   = IS_RV32 || (off != 3'b000);
          value = rdata;
        end
        default: begin
          bad   = 1'b1;
          value = '0;
        end
      endcase
    end else begin
      value = addr;
    end
    entry.reg_write = reg_write & ~bad;
    entry.load_err  = bad;
    entry.rd        = rd;
    entry.wb_data   = bad ? '0 : value;
    return entry;
  endfunction

  wb_entry_t out_q, out_d;
  wb_entry_t skid_q, skid_d;
  wb_entry_t new_entry_s;
  logic      out_valid_q, out_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;
  logic      fwd_en_q, fwd_en_d;
  logic      accept_s, consume_s;

  // Next-state for output register and skid entry; flush outranks any transfer.
  always_comb begin
    new_entry_s  = build_entry(in_mem_to_reg, in_reg_write, in_funct3,
                               in_mem_addr, in_read_data, in_rd);
    accept_s     = in_valid & in_ready_q;
    consume_s    = out_valid_q & out_ready;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d     = 1'b0;
      out_d.reg_write = 1'b0;
      skid_valid_d    = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low whenever the skid is full, so nothing is accepted here
      if (consume_s) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else begin
        out_d        = out_q;
      end
    end else if (accept_s) begin
      if (!out_valid_q || out_ready) begin
        out_d       = new_entry_s;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = new_entry_s;
        skid_valid_d = 1'b1;
      end
    end else if (consume_s) begin
      out_valid_d     = 1'b0;
      out_d.reg_write = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    in_ready_d = ~skid_valid_d;
    fwd_en_d   = out_valid_d & out_d.reg_write & (out_d.rd != '0);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      fwd_en_q     <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      fwd_en_q     <= fwd_en_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_reg_write = out_q.reg_write;
  assign out_rd        = out_q.rd;
  assign out_wb_data   = out_q.wb_data;
  assign out_load_err  = out_q.load_err;
  assign fwd_en        = fwd_en_q;
  assign fwd_rd        = out_q.rd;
  assign fwd_data      = out_q.wb_data;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (XLEN=64).
module tb_mem_wb_stage;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam logic [63:0] RDATA = 64'h8877_6655_4433_2211;

  logic            clk = 1'b0;
  logic            reset, flush, in_valid, in_ready;
  logic            in_mem_to_reg, in_reg_write;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_mem_addr, in_read_data;
  logic [RW-1:0]   in_rd;
  logic            out_valid, out_ready, out_reg_write, out_load_err, fwd_en;
  logic [RW-1:0]   out_rd, fwd_rd;
  logic [XLEN-1:0] out_wb_data, fwd_data;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_funct3(in_funct3), .in_mem_addr(in_mem_addr),
    .in_read_data(in_read_data), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_reg_write(out_reg_write), .out_rd(out_rd),
    .out_wb_data(out_wb_data), .out_load_err(out_load_err),
    .fwd_en(fwd_en), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic m2r, input logic rw,
                       input logic [2:0] f3, input logic [63:0] addr,
                       input logic [RW-1:0] rd);
    in_valid      = v;
    in_mem_to_reg = m2r;
    in_reg_write  = rw;
    in_funct3     = f3;
    in_mem_addr   = addr;
    in_read_data  = RDATA;
    in_rd         = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_reg_write, out_load_err, fwd_en} !== 4'b0000) begin
      $display("FAIL reset_flags got %b want 0000", {out_valid, out_reg_write, out_load_err, fwd_en});
      errors++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL reset_in_ready got %b want 1", in_ready);
      errors++;
    end
    checks++;
    if (out_wb_data !== 64'h0 || out_rd !== 5'd0) begin
      $display("FAIL reset_fields got %h/%0d want 0/0", out_wb_data, out_rd);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_load_extract();
    logic [2:0]  f3  [9] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b110, 3'b010, 3'b011, 3'b101, 3'b010};
    logic [63:0] adr [9] = '{64'h1005, 64'h1007, 64'h1007, 64'h1006, 64'h1004,
                             64'h1004, 64'h1000, 64'h1002, 64'h1000};
    logic [63:0] exp [9] = '{64'h66, 64'h88, 64'hFFFF_FFFF_FFFF_FF88,
                             64'hFFFF_FFFF_FFFF_8877, 64'h0000_0000_8877_6655,
                             64'hFFFF_FFFF_8877_6655, 64'h8877_6655_4433_2211,
                             64'h4433, 64'h4433_2211};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, f3[i], adr[i], 5'd3);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_load_err !== 1'b0 || out_wb_data !== exp[i]) begin
        $display("FAIL load_%0d got v=%b err=%b %h want v=1 err=0 %h",
                 i, out_valid, out_load_err, out_wb_data, exp[i]);
        errors++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_misaligned();
    logic [2:0]  f3  [4] = '{3'b010, 3'b001, 3'b011, 3'b111};
    logic [63:0] adr [4] = '{64'h1002, 64'h1001, 64'h1004, 64'h1000};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, f3[i], adr[i], 5'd9);
      step();
      checks++;
      if ({out_valid, out_load_err, out_reg_write, fwd_en} !== 4'b1100 || out_wb_data !== 64'h0) begin
        $display("FAIL misalign_%0d got vewf=%b %h want 1100 0", i,
                 {out_valid, out_load_err, out_reg_write, fwd_en}, out_wb_data);
        errors++;
      end
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b111, 64'h1003, 5'd9);
    step();
    checks++;
    if (out_load_err !== 1'b0 || out_reg_write !== 1'b1 || out_wb_data !== 64'h1003) begin
      $display("FAIL alu_no_err got err=%b rw=%b %h want 0 1 1003",
               out_load_err, out_reg_write, out_wb_data);
      errors++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_forwarding();
    out_ready = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'h1234, 5'd7);
    step();
    checks++;
    if ({out_valid, fwd_en} !== 2'b11 || fwd_rd !== 5'd7 || fwd_data !== 64'h1234) begin
      $display("FAIL fwd_rd7 got v=%b en=%b rd=%0d %h want 1 1 7 1234",
               out_valid, fwd_en, fwd_rd, fwd_data);
      errors++;
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'h1234, 5'd0);
    step();
    checks++;
    if ({out_valid, out_reg_write, fwd_en} !== 3'b110 || out_rd !== 5'd0) begin
      $display("FAIL fwd_rd0 got v/rw/en=%b rd=%0d want 110 0",
               {out_valid, out_reg_write, fwd_en}, out_rd);
      errors++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    step();
    checks++;
    if ({out_valid, fwd_en} !== 2'b00) begin
      $display("FAIL fwd_drain got v/en=%b want 00", {out_valid, fwd_en});
      errors++;
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'hA, 5'd1);
    step();
    checks++;
    if (out_valid !== 1'b1 || out_wb_data !== 64'hA || in_ready !== 1'b1) begin
      $display("FAIL bp_a got v=%b %h rdy=%b want 1 a 1", out_valid, out_wb_data, in_ready);
      errors++;
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'hB, 5'd2);
    step();
    checks++;
    if (out_wb_data !== 64'hA || in_ready !== 1'b0) begin
      $display("FAIL bp_skid got %h rdy=%b want a 0", out_wb_data, in_ready);
      errors++;
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'hC, 5'd3);
    step();
    checks++;
    if (out_wb_data !== 64'hA || out_rd !== 5'd1 || in_ready !== 1'b0) begin
      $display("FAIL bp_hold got %h rd=%0d rdy=%b want a 1 0", out_wb_data, out_rd, in_ready);
      errors++;
    end
    @(negedge clk);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_wb_data !== 64'hB || out_rd !== 5'd2 || in_ready !== 1'b1) begin
      $display("FAIL bp_b got v=%b %h rd=%0d rdy=%b want 1 b 2 1",
               out_valid, out_wb_data, out_rd, in_ready);
      errors++;
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_wb_data !== 64'hC || out_rd !== 5'd3) begin
      $display("FAIL bp_c got v=%b %h rd=%0d want 1 c 3", out_valid, out_wb_data, out_rd);
      errors++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL bp_empty got v=%b want 0", out_valid);
      errors++;
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'hD, 5'd4);
    step();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'hE, 5'd5);
    step();
    @(negedge clk);
    flush = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'hF, 5'd6);
    step();
    checks++;
    if ({out_valid, in_ready, fwd_en, out_reg_write} !== 4'b0100) begin
      $display("FAIL flush_full got v/rdy/en/rw=%b want 0100",
               {out_valid, in_ready, fwd_en, out_reg_write});
      errors++;
    end
    @(negedge clk);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'h77, 5'd6);
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL flush_incoming got v=%b rdy=%b want 0 1", out_valid, in_ready);
      errors++;
    end
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        $display("FAIL flush_ghost got v=%b %h want 0", out_valid, out_wb_data);
        errors++;
      end
    end
  endtask

  task automatic test_back_to_back_reset();
    @(negedge clk);
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'h55, 5'd8);
    step();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 3'b000, 64'h66, 5'd9);
    step();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      $display("FAIL pre_reset got v=%b rdy=%b want 1 0", out_valid, in_ready);
      errors++;
    end
    @(negedge clk);
    reset = 1'b1;
    flush = 1'b1;
    step();
    checks++;
    if ({out_valid, out_reg_write, fwd_en, in_ready} !== 4'b0001 ||
        out_wb_data !== 64'h0 || out_rd !== 5'd0) begin
      $display("FAIL mid_reset got v/rw/en/rdy=%b %h rd=%0d want 0001 0 0",
               {out_valid, out_reg_write, fwd_en, in_ready}, out_wb_data, out_rd);
      errors++;
    end
    @(negedge clk);
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      $display("FAIL post_reset got v=%b want 0", out_valid);
      errors++;
    end
  endtask

  initial begin
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 64'h0, 5'd0);
    test_reset();
    test_load_extract();
    test_misaligned();
    test_forwarding();
    test_backpressure();
    test_flush();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
